cond_exec_ctrl: RTL
===================

# cond_exec_ctrl

Sequencing controller wrapped around the processor's ARM-style condition evaluation. It owns the architectural NZCV flags register and accepts one instruction at a time over a valid/ready handshake. It stalls while a flag-setting ALU operation is still in flight, then resolves the instruction's 4-bit condition field against the settled flags. It hands the result (execute or squash, plus a branch redirect) to the execute stage and keeps execution statistics.

## Interface
- ADDR_W, 32, width of branch target / redirect PC
- CNT_W, 16, width of statistics counters
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flags_we  in  1  write flags_in into the NZCV register this cycle
- flags_in  in  4  {N,Z,C,V} from ALU
- alu_flags_pending  in  1  an issued ALU op has not yet written its flags
- flush  in  1  discard the instruction currently held
- instr_valid  in  1  upstream offers an instruction
- instr_ready  out  1  controller can accept (high only in IDLE)
- instr_cond  in  4  condition field
- instr_is_branch  in  1  instruction is a branch
- instr_target  in  ADDR_W  branch target
- exec_valid  out  1  resolved result available
- exec_ready  in  1  downstream accepts result
- exec_enable  out  1  condition met; instruction must commit
- redirect_valid  out  1  one-cycle pulse: taken branch
- redirect_pc  out  ADDR_W  target of the taken branch
- flags_out  out  4  current NZCV register {N,Z,C,V}
- busy  out  1  state != IDLE
- cnt_exec, cnt_squash, cnt_stall  out  CNT_W each  executed / squashed instructions, cycles spent in WAIT_FLAGS

## Operation
- Flags register: on flags_we, flags_q <= flags_in in any state, including the cycle of a transition.
- Condition encoding (evaluated on flags_q):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- States: IDLE, WAIT_FLAGS, EVAL, OUT.
  - IDLE: instr_ready=1. On instr_valid, capture cond/is_branch/target. Go to EVAL if cond is E or F, or if alu_flags_pending=0. Otherwise go to WAIT_FLAGS.
  - WAIT_FLAGS: cnt_stall += 1 each cycle. Go to EVAL in the cycle after alu_flags_pending is sampled 0.
  - EVAL: register met = cond_eval(flags_q). Go to OUT.
  - OUT: exec_valid=1, exec_enable=met, both held stable until exec_ready. On the handshake:
    - cnt_exec += met; cnt_squash += !met.
    - If is_branch & met: redirect_valid=1 for exactly one cycle (registered, the cycle after the handshake), with redirect_pc = captured target.
    - Go to IDLE.
- flush: from WAIT_FLAGS, EVAL or OUT, go to IDLE next cycle. No exec handshake, no redirect, counters unchanged. flush in OUT with exec_ready also asserted: flush wins. flush in IDLE: ignored, and any instruction offered that cycle is accepted normally.
- Counters wrap modulo 2^CNT_W.
- Priority: rst > flush > handshake.

## Timing
- Reset values:
  - state=IDLE; instr_ready=1 from the first cycle after reset.
  - flags_q=0000; flags_out=0000.
  - exec_valid=0, exec_enable=0, redirect_valid=0, redirect_pc=0, busy=0.
  - All counters 0.
- Reset mid-operation: the held instruction is dropped; a pending redirect pulse is suppressed.
- Minimum latency: accepted at T (IDLE) → EVAL at T+1 → exec_valid at T+2.
- Stall: each extra cycle alu_flags_pending stays high after acceptance adds one cycle and one cnt_stall increment.
- flags_we in the same cycle pending drops: the written value is used by EVAL.
- flags_we during EVAL: the old flags_q is used; the new value applies to the next instruction.
- Back-to-back throughput: one instruction per 3 cycles when exec_ready is tied high (OUT → IDLE → EVAL → OUT).
- redirect_valid is asserted in the cycle the controller is back in IDLE. It may coincide with a new instr_valid, which is accepted.
- flags_out = flags_q, registered. No combinational paths from inputs to instr_ready or exec_valid.

## Test plan
- Reset, then flags_we with 0100 (Z=1); issue cond=0 (EQ), branch, target 0x100, exec_ready=1 → exec_valid at T+2, exec_enable=1, redirect_valid one cycle with redirect_pc=0x100, cnt_exec=1.
- Flags 0000; issue cond=0 with alu_flags_pending high 3 cycles, then flags_we=0100 as pending drops → cnt_stall=3, exec_enable=1. Repeat with flags 1001 (N=1,V=1): cond=C (GT) gives 1, cond=B (LT) gives 0.
- Sweep all 16 conds × all 16 flag values with pending=0 → exec_enable matches the encoding table; cnt_exec+cnt_squash=256; cond=F never redirects.
- Hold exec_ready=0 for 5 cycles in OUT → exec_valid/exec_enable stable, instr_ready=0, then one redirect after release. Assert flush with exec_ready in OUT → no redirect, counters unchanged, IDLE next cycle.
- Assert rst while in WAIT_FLAGS with flags=1111 → flags_out=0000, busy=0, counters 0, no exec_valid. Drive cnt_squash to 0xFFFF, one more squash → wraps to 0.

Source files
------------

// File: rtl/cond_exec_ctrl.sv
// rtl/cond_exec_ctrl.sv - condition-evaluation sequencer owning the NZCV flags register
//
// Accepts one conditional instruction at a time, stalls while a flag-setting
// ALU op is still in flight, resolves the 4-bit condition against the settled
// flags and presents execute/squash (plus a taken-branch redirect) downstream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flags_we, flags_in  NZCV register write {N,Z,C,V}
//   alu_flags_pending   an issued ALU op has not yet written its flags
//   flush               drop the instruction currently held
//   instr_*             upstream valid/ready instruction channel
//   exec_*              downstream valid/ready result channel
//   redirect_valid/pc   one-cycle taken-branch pulse and its target
//   flags_out           current NZCV register
//   busy                controller holds an instruction
//   cnt_exec/squash/stall  wrapping statistics counters

module cond_exec_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  input  logic              alu_flags_pending,
  input  logic              flush,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_cond,
  input  logic              instr_is_branch,
  input  logic [ADDR_W-1:0] instr_target,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic              exec_enable,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [3:0]        flags_out,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_exec,
  output logic [CNT_W-1:0]  cnt_squash,
  output logic [CNT_W-1:0]  cnt_stall
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_EVAL       = 2'd2,
    S_OUT        = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [3:0]          flags_q;
  logic [3:0]          cond_q;
  logic                is_branch_q;
  logic [ADDR_W-1:0]   target_q;
  logic                exec_valid_q;
  logic                exec_enable_q;
  logic                redirect_valid_q;
  logic [ADDR_W-1:0]   redirect_pc_q;
  logic [CNT_W-1:0]    cnt_exec_q;
  logic [CNT_W-1:0]    cnt_squash_q;
  logic [CNT_W-1:0]    cnt_stall_q;

  // ARM condition table evaluated on {N,Z,C,V}.
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic met;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    met = z;
      4'h1:    met = !z;
      4'h2:    met = c;
      4'h3:    met = !c;
      4'h4:    met = n;
      4'h5:    met = !n;
      4'h6:    met = v;
      4'h7:    met = !v;
      4'h8:    met = c && !z;
      4'h9:    met = !c || z;
      4'hA:    met = (n == v);
      4'hB:    met = (n != v);
      4'hC:    met = !z && (n == v);
      4'hD:    met = z || (n != v);
      4'hE:    met = 1'b1;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      flags_q          <= 4'b0000;
      cond_q           <= 4'h0;
      is_branch_q      <= 1'b0;
      target_q         <= '0;
      exec_valid_q     <= 1'b0;
      exec_enable_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_exec_q       <= '0;
      cnt_squash_q     <= '0;
      cnt_stall_q      <= '0;
    end else begin
      // Redirect is a single-cycle pulse; only the OUT handshake re-arms it.
      redirect_valid_q <= 1'b0;

      // The flags register is written independently of the sequencer state,
      // so a write on the cycle pending drops is visible to the following EVAL.
      if (flags_we) begin
        flags_q <= flags_in;
      end

      case (state_q)
        S_IDLE: begin
          // flush is meaningless here: nothing is held.
          if (instr_valid) begin
            cond_q      <= instr_cond;
            is_branch_q <= instr_is_branch;
            target_q    <= instr_target;
            // AL/NV never read the flags, so they never wait on the ALU.
            if ((instr_cond[3:1] == 3'b111) || !alu_flags_pending) begin
              state_q <= S_EVAL;
            end else begin
              state_q <= S_WAIT_FLAGS;
            end
          end
        end

        S_WAIT_FLAGS: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            cnt_stall_q <= cnt_stall_q + CNT_ONE;
            if (!alu_flags_pending) begin
              state_q <= S_EVAL;
            end
          end
        end

        S_EVAL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            // Uses the flags as they stood entering this cycle; a write
            // landing now belongs to the next instruction.
            exec_valid_q  <= 1'b1;
            exec_enable_q <= cond_met(cond_q, flags_q);
            state_q       <= S_OUT;
          end
        end

        S_OUT: begin
          if (flush) begin
            exec_valid_q  <= 1'b0;
            exec_enable_q <= 1'b0;
            state_q       <= S_IDLE;
          end else if (exec_ready) begin
            if (exec_enable_q) begin
              cnt_exec_q <= cnt_exec_q + CNT_ONE;
            end else begin
              cnt_squash_q <= cnt_squash_q + CNT_ONE;
            end
            if (is_branch_q && exec_enable_q) begin
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target_q;
            end
            exec_valid_q  <= 1'b0;
            exec_enable_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers; none depends on an input.
  assign instr_ready    = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign exec_valid     = exec_valid_q;
  assign exec_enable    = exec_enable_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flags_out      = flags_q;
  assign cnt_exec       = cnt_exec_q;
  assign cnt_squash     = cnt_squash_q;
  assign cnt_stall      = cnt_stall_q;

endmodule
